// File: rtl/adder_pkg.sv
// Shared definitions for the pipelined ripple-carry adder: slice width helper and
// the per-stage record layout.
package adder_pkg;

    localparam int ADDER_MAX_N = 64;

    function automatic int slice_w(input int n, input int stages);
        return (stages < 1) ? 1 : n / stages;
    endfunction

    // Register contents of one stage, shown at the widest supported operand size.
    typedef struct packed {
        logic                   valid;
        logic                   carry;
        logic [ADDER_MAX_N-1:0] sum;
        logic [ADDER_MAX_N-1:0] rem_a;
        logic [ADDER_MAX_N-1:0] rem_b;
    } stage_rec_t;

endpackage

// File: rtl/adder_pipe_stage.sv
// One pipeline stage: a W-bit ripple slice of full adders feeding the stage register,
// with the backpressure (advance) term for this stage.
module full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_s,
    output logic o_c
);
    assign o_s = i_a ^ i_b ^ i_c;
    assign o_c = (i_a & i_b) | (i_c & (i_a ^ i_b));
endmodule

module adder_pipe_stage #(
    parameter int N = 16,
    parameter int W = 4,
    parameter int K = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_valid,
    input  logic         i_carry,
    input  logic [N-1:0] i_sum,
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic         i_adv_next,
    output logic         o_adv,
    output logic         o_valid,
    output logic         o_carry,
    output logic [N-1:0] o_sum,
    output logic [N-1:0] o_a,
    output logic [N-1:0] o_b
);
    logic [W:0]   w_c;
    logic [W-1:0] w_s;
    logic         r_valid;
    logic         r_carry;
    logic [N-1:0] r_sum;
    logic [N-1:0] r_a;
    logic [N-1:0] r_b;

    // Remaining operand bits arrive shifted down, so this slice always sits at the LSBs.
    assign w_c[0] = i_carry;
    for (genvar i = 0; i < W; i++) begin : g_fa
        full_adder u_fa (
            .i_a (i_a[i]),
            .i_b (i_b[i]),
            .i_c (w_c[i]),
            .o_s (w_s[i]),
            .o_c (w_c[i+1])
        );
    end

    assign o_adv = !r_valid || i_adv_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_carry <= 1'b0;
            r_sum   <= '0;
            r_a     <= '0;
            r_b     <= '0;
        end else if (o_adv) begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_carry <= w_c[W];
                r_sum   <= i_sum | (N'(w_s) << (K * W));
                r_a     <= i_a >> W;
                r_b     <= i_b >> W;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_carry = r_carry;
    assign o_sum   = r_sum;
    assign o_a     = r_a;
    assign o_b     = r_b;
endmodule

// File: rtl/pipelined_ripple_adder.sv
// N-bit adder split into STAGES registered ripple slices with valid/ready on both sides.
// Define PIPELINED_ADDER_OVF_EN to add the signed-overflow output ovf.
module pipelined_ripple_adder
    import adder_pkg::*;
#(
    parameter int N      = 16,
    parameter int STAGES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         cout
`ifdef PIPELINED_ADDER_OVF_EN
    ,
    output logic         ovf
`endif
);
    localparam int W = slice_w(N, STAGES);

    if (STAGES < 1) begin : g_bad_stages
        $error("pipelined_ripple_adder: STAGES must be at least 1");
    end else if (N % STAGES != 0) begin : g_bad_width
        $error("pipelined_ripple_adder: N must be a multiple of STAGES");
    end

    // Index 0 is the input side; index k+1 is the register of stage k.
    logic         w_valid [0:STAGES];
    logic         w_carry [0:STAGES];
    logic [N-1:0] w_sum   [0:STAGES];
    logic [N-1:0] w_a     [0:STAGES];
    logic [N-1:0] w_b     [0:STAGES];
    logic         w_adv   [0:STAGES];

    assign w_valid[0]    = in_valid;
    assign w_carry[0]    = cin;
    assign w_sum[0]      = '0;
    assign w_a[0]        = a;
    assign w_b[0]        = b;
    assign w_adv[STAGES] = out_ready;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        adder_pipe_stage #(
            .N (N),
            .W (W),
            .K (k)
        ) u_stage (
            .clk        (clk),
            .rst_n      (rst_n),
            .i_valid    (w_valid[k]),
            .i_carry    (w_carry[k]),
            .i_sum      (w_sum[k]),
            .i_a        (w_a[k]),
            .i_b        (w_b[k]),
            .i_adv_next (w_adv[k+1]),
            .o_adv      (w_adv[k]),
            .o_valid    (w_valid[k+1]),
            .o_carry    (w_carry[k+1]),
            .o_sum      (w_sum[k+1]),
            .o_a        (w_a[k+1]),
            .o_b        (w_b[k+1])
        );
    end

    assign in_ready  = w_adv[0];
    assign out_valid = w_valid[STAGES];
    assign sum       = w_sum[STAGES];
    assign cout      = w_carry[STAGES];

`ifdef PIPELINED_ADDER_OVF_EN
    logic r_sign_a;
    logic r_sign_b;

    // Operand sign bits sit at the top of the last slice and travel with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
        end else if (w_adv[STAGES-1] && w_valid[STAGES-1]) begin
            r_sign_a <= w_a[STAGES-1][W-1];
            r_sign_b <= w_b[STAGES-1][W-1];
        end
    end

    assign ovf = (r_sign_a == r_sign_b) && (sum[N-1] != r_sign_a);
`endif
endmodule

// File: tb/tb_pipelined_ripple_adder.sv
// Scoreboard bench for pipelined_ripple_adder (N=16, STAGES=4); build with
// PIPELINED_ADDER_OVF_EN to also check ovf.
module tb_pipelined_ripple_adder;
    localparam int N      = 16;
    localparam int STAGES = 4;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        c;
        logic [15:0] s;
        logic        co;
        logic        ov;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        cin = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] sum;
    logic        cout;
`ifdef PIPELINED_ADDER_OVF_EN
    logic        ovf;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic [17:0] sb_q[$];

    pipelined_ripple_adder #(.N(N), .STAGES(STAGES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef PIPELINED_ADDER_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Monitor: every output handshake pops the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output: got sum 0x%0h, expected no output", sum);
            end else begin
                logic [17:0] e;
                e = sb_q.pop_front();
                check("sum", 32'(sum), 32'(e[15:0]));
                check("cout", 32'(cout), 32'(e[16]));
`ifdef PIPELINED_ADDER_OVF_EN
                check("ovf", 32'(ovf), 32'(e[17]));
`endif
            end
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input vec_t v, output int tries);
        logic rdy;
        a = v.a; b = v.b; cin = v.c; in_valid = 1'b1;
        tries = 0;
        rdy = 1'b0;
        for (int n = 0; n < 200 && !rdy; n++) begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            tries++;
        end
        if (rdy) sb_q.push_back({v.ov, v.co, v.s});
        else begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: got no in_ready, expected accept");
        end
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 100 && sb_q.size() != 0; n++) @(posedge clk);
        repeat (2) @(posedge clk);
        #1;
        check("drain_queue_empty", 32'(sb_q.size()), 32'd0);
    endtask

    vec_t stream_v [12] = '{
        '{16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0},
        '{16'h000F, 16'h0001, 1'b0, 16'h0010, 1'b0, 1'b0},
        '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0},
        '{16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0, 1'b0},
        '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1},
        '{16'hAAAA, 16'h5555, 1'b0, 16'hFFFF, 1'b0, 1'b0},
        '{16'hAAAA, 16'h5555, 1'b1, 16'h0000, 1'b1, 1'b0},
        '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0},
        '{16'hF0F0, 16'h0F0F, 1'b0, 16'hFFFF, 1'b0, 1'b0},
        '{16'hC000, 16'h4000, 1'b0, 16'h0000, 1'b1, 1'b0},
        '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1},
        '{16'hDEAD, 16'hBEEF, 1'b0, 16'h9D9C, 1'b1, 1'b0}
    };

    vec_t stall_v [5] = '{
        '{16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0},
        '{16'h0F0F, 16'h0101, 1'b0, 16'h1010, 1'b0, 1'b0},
        '{16'hFFFE, 16'h0003, 1'b0, 16'h0001, 1'b1, 1'b0},
        '{16'h4000, 16'h4000, 1'b1, 16'h8001, 1'b0, 1'b1},
        '{16'h0123, 16'h0321, 1'b0, 16'h0444, 1'b0, 1'b0}
    };

    vec_t misc_v [5] = '{
        '{16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0},
        '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0},
        '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0},
        '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1},
        '{16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1}
    };

    initial begin
        int tries;
        int lat;
        int run_len;
        int seen;

        // Reset state
        #12;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("in_ready_after_reset", 32'(in_ready), 32'd1);

        // Single add and latency: captured on the accept edge, visible three edges later
        send(misc_v[0], tries);
        lat = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (out_valid) break;
            lat++;
            @(posedge clk);
        end
        check("latency_edges_after_accept", 32'(lat), 32'(STAGES - 1));
        @(posedge clk);
        @(negedge clk);
        check("out_valid_single_cycle", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;

        // Carry through every slice boundary
        send(misc_v[1], tries);
        send(misc_v[2], tries);
        drain();

        // Back-to-back stream with full throughput
        fork
            begin
                for (int i = 0; i < 12; i++) begin
                    send(stream_v[i], tries);
                    check("stream_first_try_accept", 32'(tries), 32'd1);
                end
            end
            begin
                run_len = 0;
                for (int n = 0; n < 50; n++) begin
                    @(negedge clk);
                    if (out_valid) break;
                end
                for (int n = 0; n < 40 && out_valid; n++) begin
                    run_len++;
                    @(negedge clk);
                end
            end
        join
        check("stream_no_gaps", 32'(run_len), 32'd12);
        drain();

        // Backpressure: fill the pipe, stall five cycles, release
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(stall_v[i], tries);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_in_ready", 32'(in_ready), 32'd0);
            check("stall_out_valid", 32'(out_valid), 32'd1);
            check("stall_sum_held", 32'(sum), 32'h3333);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(stall_v[4], tries);
        check("release_accept_first_try", 32'(tries), 32'd1);
        drain();

        // Reset with three results in flight
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(stream_v[i], tries);
        @(posedge clk);
        #1;
        check("pre_reset_out_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_reset_out_valid", 32'(out_valid), 32'd0);
        check("mid_reset_sum", 32'(sum), 32'd0);
        check("mid_reset_cout", 32'(cout), 32'd0);
        sb_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("no_stale_after_reset", 32'(seen), 32'd0);
        check("in_ready_after_mid_reset", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Signed-overflow corner vectors
        send(misc_v[3], tries);
        send(misc_v[4], tries);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
